// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator:
// mode encodings, ramp direction and prescaler sizing.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic int presc_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, up or up/down counter and
// the period-boundary detect used to reload the shadows.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PERIOD   = 15,
    parameter int PRESCALE = 1
) (
    input  logic             cLK,
    input  logic             Reset,
    input  logic             en,
    input  logic             mode,
    output logic [WIDTH-1:0] cnt,
    output logic             boundary
);

    localparam int PW = presc_width(PRESCALE);
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(PERIOD - 1);

    logic [PW-1:0]    presc_q, presc_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    dir_e             dir_q, dir_d;
    logic             tick;

    assign tick = en && (presc_q == PS_LAST);

    always_comb begin
        presc_d  = presc_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        boundary = 1'b0;
        if (!en) begin
            presc_d = '0;
            cnt_d   = '0;
            dir_d   = DIR_UP;
        end else begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                unique case (mode)
                    MODE_EDGE: begin
                        if (cnt_q == CNT_LAST) begin
                            boundary = 1'b1;
                            cnt_d    = '0;
                            dir_d    = DIR_UP;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    MODE_CENTER: begin
                        // Both turning points hold the count for one
                        // extra tick while the direction flips.
                        unique case (dir_q)
                            DIR_UP: begin
                                if (cnt_q == CNT_LAST) dir_d = DIR_DOWN;
                                else cnt_d = cnt_q + 1'b1;
                            end
                            DIR_DOWN: begin
                                if (cnt_q == '0) begin
                                    boundary = 1'b1;
                                    dir_d    = DIR_UP;
                                end else begin
                                    cnt_d = cnt_q - 1'b1;
                                end
                            end
                        endcase
                    end
                endcase
            end
        end
    end

    always_ff @(posedge cLK or posedge Reset) begin
        if (Reset) begin
            presc_q <= '0;
            cnt_q   <= '0;
            dir_q   <= DIR_UP;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pwm_multi_generator.sv
// Multi-channel PWM: one shared timebase, double-buffered duty
// and mode, per-channel polarity and a period-end strobe.
module pwm_multi_generator
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PERIOD   = 15,
    parameter int CHANNELS = 4,
    parameter int PRESCALE = 1
) (
    input  logic                      cLK,
    input  logic                      Reset,
    input  logic                      en,
    input  logic                      mode,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic [CHANNELS-1:0]       pol,
    output logic [CHANNELS-1:0]       pwm,
    output logic                      period_end,
    output logic [WIDTH-1:0]          cnt
);

    if (PERIOD < 2 || PERIOD > (2 ** WIDTH) - 1) begin : g_bad_period
        $fatal(1, "pwm_multi_generator: PERIOD out of range");
    end
    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $fatal(1, "pwm_multi_generator: PRESCALE out of range");
    end

    logic                      boundary;
    logic [CHANNELS*WIDTH-1:0] duty_q, duty_d;
    logic                      mode_q, mode_d;
    logic [CHANNELS-1:0]       pwm_q, pwm_d;
    logic                      period_end_q, period_end_d;

    pwm_timebase #(
        .WIDTH   (WIDTH),
        .PERIOD  (PERIOD),
        .PRESCALE(PRESCALE)
    ) u_timebase (
        .cLK     (cLK),
        .Reset   (Reset),
        .en      (en),
        .mode    (mode_q),
        .cnt     (cnt),
        .boundary(boundary)
    );

    // While disabled the shadows track the inputs, so the first
    // period after enable already uses the current settings.
    always_comb begin
        duty_d       = duty_q;
        mode_d       = mode_q;
        period_end_d = boundary;
        if (!en || boundary) begin
            duty_d = duty;
            mode_d = mode;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign pwm_d[g] = en
            ? ((cnt < duty_q[g*WIDTH +: WIDTH]) ^ pol[g])
            : pol[g];
    end

    always_ff @(posedge cLK or posedge Reset) begin
        if (Reset) begin
            duty_q       <= '0;
            mode_q       <= MODE_EDGE;
            pwm_q        <= '0;
            period_end_q <= 1'b0;
        end else begin
            duty_q       <= duty_d;
            mode_q       <= mode_d;
            pwm_q        <= pwm_d;
            period_end_q <= period_end_d;
        end
    end

    assign pwm        = pwm_q;
    assign period_end = period_end_q;

endmodule

// File: tb/tb_pwm_multi_generator.sv
// Bench for pwm_multi_generator: PRESCALE=1 and PRESCALE=3 copies
// driven in parallel and checked against a period-phase model.
module tb_pwm_multi_generator;

    localparam int P = 15;

    logic        cLK = 1'b0;
    logic        Reset, en, mode;
    logic [15:0] duty;
    logic [3:0]  pol;
    logic [3:0]  pwm0, pwm1, cnt0, cnt1;
    logic        pe0, pe1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 cLK = ~cLK;

    pwm_multi_generator #(
        .WIDTH(4), .PERIOD(P), .CHANNELS(4), .PRESCALE(1)
    ) u0 (
        .cLK(cLK), .Reset(Reset), .en(en), .mode(mode),
        .duty(duty), .pol(pol),
        .pwm(pwm0), .period_end(pe0), .cnt(cnt0)
    );

    pwm_multi_generator #(
        .WIDTH(4), .PERIOD(P), .CHANNELS(4), .PRESCALE(3)
    ) u1 (
        .cLK(cLK), .Reset(Reset), .en(en), .mode(mode),
        .duty(duty), .pol(pol),
        .pwm(pwm1), .period_end(pe1), .cnt(cnt1)
    );

    // Model: position in the period (phase) plus prescale count.
    int         psv [2] = '{1, 3};
    int         m_pc [2];
    int         m_ph [2];
    int         m_mact [2];
    int         m_dact [2][4];
    logic [3:0] m_pwm [2];
    logic       m_pe [2];
    logic [3:0] m_cnt [2];

    int hi [4];
    int pes;

    function automatic int cnt_of(input int ph, input int md);
        if (md == 0 || ph < P) return ph;
        return 2 * P - 1 - ph;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 0; m_ph[k] = 0; m_mact[k] = 0;
            m_pwm[k] = '0; m_pe[k] = 1'b0; m_cnt[k] = '0;
            for (int i = 0; i < 4; i++) m_dact[k][i] = 0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int c, len;
            c = cnt_of(m_ph[k], m_mact[k]);
            m_pe[k] = 1'b0;
            if (!en) begin
                m_pwm[k] = pol;
                m_pc[k] = 0;
                m_ph[k] = 0;
                m_mact[k] = int'(mode);
                for (int i = 0; i < 4; i++)
                    m_dact[k][i] = int'(duty[i*4 +: 4]);
            end else begin
                for (int i = 0; i < 4; i++)
                    m_pwm[k][i] = (c < m_dact[k][i]) ^ pol[i];
                if (m_pc[k] == psv[k] - 1) begin
                    m_pc[k] = 0;
                    len = (m_mact[k] != 0) ? 2 * P : P;
                    if (m_ph[k] == len - 1) begin
                        m_pe[k] = 1'b1;
                        m_ph[k] = 0;
                        m_mact[k] = int'(mode);
                        for (int i = 0; i < 4; i++)
                            m_dact[k][i] = int'(duty[i*4 +: 4]);
                    end else begin
                        m_ph[k]++;
                    end
                end else begin
                    m_pc[k]++;
                end
            end
            m_cnt[k] = 4'(cnt_of(m_ph[k], m_mact[k]));
        end
    endtask

    task automatic step();
        model_step();
        @(posedge cLK);
        #1;
    endtask

    task automatic run_count(input int k, input int n);
        for (int i = 0; i < 4; i++) hi[i] = 0;
        pes = 0;
        repeat (n) begin
            step();
            for (int i = 0; i < 4; i++)
                hi[i] += int'(k == 0 ? pwm0[i] : pwm1[i]);
            pes += int'(k == 0 ? pe0 : pe1);
        end
    endtask

    task automatic sync_pe(input int k, output bit ok);
        int t = 0;
        ok = 1'b0;
        while (!ok && t < 400) begin
            step();
            t++;
            ok = ((k == 0) ? pe0 : pe1) === 1'b1;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; en = 1'b1; mode = 1'b0;
        pol = 4'b0101; duty = 16'($urandom);
        model_reset();
        #1;
        for (int r = 0; r < 3; r++) begin
            n_cmp++;
            if ({pwm0, pe0, cnt0, pwm1, pe1, cnt1} !== 18'd0) begin
                n_bad++;
                $display("FAIL reset_hold: got %h/%b/%h %h/%b/%h, want zeros",
                         pwm0, pe0, cnt0, pwm1, pe1, cnt1);
            end
            @(posedge cLK);
            #1;
        end
        Reset = 1'b0;
        step();
        n_cmp++;
        if (pwm0 !== 4'b0101 || pwm1 !== 4'b0101) begin
            n_bad++;
            $display("FAIL reset_release: got %b %b, want 0101", pwm0, pwm1);
        end
        duty = 16'hFFFF;
        repeat (20) step();
        n_cmp++;
        if ({pwm0, pe0, cnt0} !== {m_pwm[0], m_pe[0], m_cnt[0]}) begin
            n_bad++;
            $display("FAIL pre_async_reset: got %h/%b/%h, want %h/%b/%h",
                     pwm0, pe0, cnt0, m_pwm[0], m_pe[0], m_cnt[0]);
        end
        Reset = 1'b1;
        #2;
        n_cmp++;
        if ({pwm0, pe0, cnt0, pwm1, cnt1} !== 17'd0) begin
            n_bad++;
            $display("FAIL async_reset: got %h/%b/%h %h/%h, want zeros",
                     pwm0, pe0, cnt0, pwm1, cnt1);
        end
        @(posedge cLK);
        #1;
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic test_edge();
        bit ok;
        int e;
        mode = 1'b0; pol = 4'b0000;
        duty = 16'($urandom);
        duty[3:0] = 4'd5;
        sync_pe(0, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL edge_sync: got no period_end, want one");
        end
        for (int p = 0; p < 3; p++) begin
            run_count(0, P);
            for (int i = 0; i < 4; i++) begin
                e = int'(duty[i*4 +: 4]);
                if (e > P) e = P;
                n_cmp++;
                if (hi[i] != e) begin
                    n_bad++;
                    $display("FAIL edge_high ch%0d: got %0d, want %0d",
                             i, hi[i], e);
                end
            end
            n_cmp++;
            if (pes != 1 || pe0 !== 1'b1) begin
                n_bad++;
                $display("FAIL edge_pe: got %0d/%b, want 1/1", pes, pe0);
            end
        end
    endtask

    task automatic test_limits();
        bit ok;
        duty = 16'h01F0; pol = 4'b0000;
        sync_pe(0, ok);
        run_count(0, P);
        n_cmp++;
        if (!ok || hi[0] != 0 || hi[1] != 15 || hi[2] != 1 || hi[3] != 0) begin
            n_bad++;
            $display("FAIL limits: got %0d %0d %0d %0d, want 0 15 1 0",
                     hi[0], hi[1], hi[2], hi[3]);
        end
        pol = 4'b1111;
        run_count(0, P);
        n_cmp++;
        if (hi[0] != 15 || hi[1] != 0 || hi[2] != 14 || pes != 1) begin
            n_bad++;
            $display("FAIL limits_pol: got %0d %0d %0d pe%0d, want 15 0 14 pe1",
                     hi[0], hi[1], hi[2], pes);
        end
    endtask

    task automatic test_midchange();
        bit ok;
        int h = 0;
        pol = 4'b0000;
        duty[3:0] = 4'd5;
        sync_pe(0, ok);
        for (int j = 1; j <= P; j++) begin
            step();
            h += int'(pwm0[0]);
            if (j == 7) begin
                n_cmp++;
                if (cnt0 !== 4'd7) begin
                    n_bad++;
                    $display("FAIL mid_cnt: got %0d, want 7", cnt0);
                end
                duty[3:0] = 4'd10;
            end
        end
        n_cmp++;
        if (!ok || h != 5 || pe0 !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_current: got %0d/%b, want 5/1", h, pe0);
        end
        run_count(0, P);
        n_cmp++;
        if (hi[0] != 10) begin
            n_bad++;
            $display("FAIL mid_next: got %0d, want 10", hi[0]);
        end
    endtask

    task automatic test_center();
        bit ok;
        int bad = 0;
        int h = 0;
        mode = 1'b1; pol = 4'b0000;
        duty[3:0] = 4'd4;
        sync_pe(0, ok);
        pes = 0;
        for (int j = 0; j < 2 * P; j++) begin
            step();
            if (pwm0[0] !== ((j < 4 || j >= 26) ? 1'b1 : 1'b0)) bad++;
            pes += int'(pe0);
        end
        n_cmp++;
        if (!ok || bad != 0 || pes != 1 || pe0 !== 1'b1) begin
            n_bad++;
            $display("FAIL center_shape: got bad=%0d pe=%0d/%b, want 0 1/1",
                     bad, pes, pe0);
        end
        pes = 0;
        for (int j = 0; j < 2 * P; j++) begin
            if (j == 10) mode = 1'b0;
            step();
            h += int'(pwm0[0]);
            pes += int'(pe0);
        end
        n_cmp++;
        if (h != 8 || pes != 1 || pe0 !== 1'b1) begin
            n_bad++;
            $display("FAIL center_switch: got %0d pe=%0d/%b, want 8 1/1",
                     h, pes, pe0);
        end
        run_count(0, P);
        n_cmp++;
        if (hi[0] != 4 || pes != 1) begin
            n_bad++;
            $display("FAIL center_to_edge: got %0d pe=%0d, want 4 1",
                     hi[0], pes);
        end
    endtask

    task automatic test_prescale();
        bit ok;
        int t = 0;
        mode = 1'b0; duty = 16'h5555; pol = 4'b0001;
        sync_pe(1, ok);
        run_count(1, 3 * P);
        n_cmp++;
        if (!ok || 3 * P - hi[0] != 15 || hi[1] != 15 || pes != 1) begin
            n_bad++;
            $display("FAIL presc_period: got low=%0d hi1=%0d pe=%0d, want 15 15 1",
                     3 * P - hi[0], hi[1], pes);
        end
        while (cnt1 !== 4'd9 && t < 60) begin
            step();
            t++;
        end
        n_cmp++;
        if (cnt1 !== 4'd9) begin
            n_bad++;
            $display("FAIL presc_find9: got %0d, want 9", cnt1);
        end
        en = 1'b0;
        for (int j = 0; j < 4; j++) begin
            step();
            n_cmp++;
            if (pwm1 !== 4'b0001 || cnt1 !== 4'd0 || pe1 !== 1'b0) begin
                n_bad++;
                $display("FAIL presc_disabled: got %b/%0d/%b, want 0001/0/0",
                         pwm1, cnt1, pe1);
            end
        end
        en = 1'b1;
        for (int j = 0; j < 2; j++) begin
            step();
            n_cmp++;
            if (cnt1 !== 4'd0 || pe1 !== 1'b0) begin
                n_bad++;
                $display("FAIL presc_restart: got %0d/%b, want 0/0", cnt1, pe1);
            end
        end
        run_count(1, 42);
        step();
        n_cmp++;
        if (pes != 0 || pe1 !== 1'b1) begin
            n_bad++;
            $display("FAIL presc_first_pe: got %0d/%b, want 0/1", pes, pe1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 999) < 5) begin
                Reset = 1'b1;
                @(posedge cLK);
                #1;
                Reset = 1'b0;
                model_reset();
            end else begin
                if (en && $urandom_range(0, 99) < 2) en = 1'b0;
                else if (!en && $urandom_range(0, 99) < 10) en = 1'b1;
                if ($urandom_range(0, 99) < 8) duty = 16'($urandom);
                if ($urandom_range(0, 99) < 2) mode = ~mode;
                if ($urandom_range(0, 99) < 4) pol = 4'($urandom);
                step();
            end
            n_cmp++;
            if ({pwm0, pe0, cnt0} !== {m_pwm[0], m_pe[0], m_cnt[0]}) begin
                n_bad++;
                $display("FAIL random_u0 @%0d: got %h/%b/%h, want %h/%b/%h",
                         n, pwm0, pe0, cnt0, m_pwm[0], m_pe[0], m_cnt[0]);
            end
            n_cmp++;
            if ({pwm1, pe1, cnt1} !== {m_pwm[1], m_pe[1], m_cnt[1]}) begin
                n_bad++;
                $display("FAIL random_u1 @%0d: got %h/%b/%h, want %h/%b/%h",
                         n, pwm1, pe1, cnt1, m_pwm[1], m_pe[1], m_cnt[1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_edge();
        test_limits();
        test_midchange();
        test_center();
        test_prescale();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_multi_generator.md
Name: pwm_multi_generator

Overview:
Parametrised multi-channel PWM generator, the successor of the single-channel 4-bit ADC-driven PWM block. One shared timebase drives CHANNELS comparators. Each channel's duty is double-buffered and updated only at period boundaries, so outputs never glitch. Adds a prescaler, an edge- or centre-aligned mode, per-channel polarity, a global enable and a period-end strobe, for use by motor/LED/servo stages downstream of the ADC.

Parameters:
WIDTH, 4, bit width of counter and of each duty word
PERIOD, 15, counts per ramp; legal range 2..2^WIDTH-1
CHANNELS, 4, number of PWM outputs
PRESCALE, 1, cLK cycles per counter tick; legal range 1..65535

Ports:
cLK  in  1  system clock; all logic is on the rising edge
Reset  in  1  asynchronous, active-high reset
en  in  1  global enable
mode  in  1  0 = edge-aligned, 1 = centre-aligned; shadowed
duty  in  CHANNELS*WIDTH  packed duty words; channel i is duty[i*WIDTH +: WIDTH]; shadowed
pol  in  CHANNELS  per-channel output inversion, 1 = active-low
pwm  out  CHANNELS  PWM outputs, registered
period_end  out  1  one-cycle strobe on the tick that completes a period, registered
cnt  out  WIDTH  current timebase count, for debug and ADC sync

Behaviour:
- Reset: applies immediately and asynchronously. Prescaler = 0, cnt = 0, dir = up, active duty = 0, active mode = 0, pwm = 0, period_end = 0.
- Tick: one-cycle internal pulse when the prescaler reaches PRESCALE-1; the prescaler then wraps to 0. With PRESCALE = 1, every en cycle is a tick. cnt and dir change only on ticks.
- Edge mode: cnt runs 0,1,...,PERIOD-1 and then wraps to 0. The period is PERIOD ticks.
- Centre mode: cnt runs 0 up to PERIOD-1, holds PERIOD-1 for one extra tick while dir flips to down, counts down to 0, holds 0 for one extra tick while dir flips to up. The period is 2*PERIOD ticks.
- Boundary tick:
  - Edge mode: the tick with cnt = PERIOD-1.
  - Centre mode: the tick with cnt = 0 and dir = down.
  - On this tick, active duty and active mode load from the inputs, and period_end = 1 for the following cycle.
  - New values take effect from count 0 of the next period.
  - A duty or mode change mid-period never affects the current period.
- Compare: on every en cycle, pwm[i] <= (cnt < duty_act[i]) XOR pol[i], evaluated on the pre-edge cnt. pwm therefore lags cnt by exactly one cycle.
  - duty = 0 gives a constant inactive level (0% duty).
  - duty >= PERIOD gives a constant active level (100% duty).
  - Edge mode: high time = duty ticks per period.
  - Centre mode: high time = 2*duty ticks, centred on the valley.
- pol: not shadowed; it takes effect on the next cycle.
- en = 0:
  - Prescaler, cnt and dir are held at 0 / 0 / up.
  - pwm <= pol, which is the inactive level; period_end <= 0.
  - Shadow registers load from duty and mode every cycle, so the first period after enable uses the current inputs.
- en rising: on the first en = 1 cycle, cnt = 0 and compares are evaluated. No period_end is emitted for the partial start.
- Simultaneous events: Reset overrides everything. en = 0 overrides a boundary tick. A duty input change on the boundary cycle is captured.
- Width rules: comparisons are unsigned at WIDTH bits. PERIOD and PRESCALE are checked at elaboration, and an illegal value is a fatal error.

Decomposition:
- Shared package pwm_pkg holds:
  - the mode encodings MODE_EDGE = 1'b0 and MODE_CENTER = 1'b1;
  - a function for the prescaler counter width, clog2(PRESCALE), minimum 1.
- Sub-module pwm_timebase (prescaler, cnt, dir, tick, boundary detect) is instantiated once.
- The top level holds the shadow registers and the generate-loop comparators.

Test Plan:
1. Reset with pol = 4'b0101, en = 1 → pwm = 4'b0000 while Reset is high; after release, pwm matches duty/pol on the next cycle; cnt = 0 and period_end = 0 while Reset is held.
2. Edge mode, PRESCALE = 1, en = 1, duty ch0 = 5 → ch0 high 5 cycles then low 10 cycles, repeating; period_end pulses every 15 cycles, one cycle after cnt = 14.
3. duty ch0 = 0, ch1 = 15, ch2 = 1, pol = 0 → ch0 constantly 0; ch1 constantly 1; ch2 high for 1 cycle in each 15.
4. Edge mode, duty ch0 changes 5 → 10 at cnt = 7 → the current period still shows 5 high cycles; the next period shows 10 high cycles; no runt pulse.
5. Centre mode, duty ch0 = 4 → 8 high ticks centred on the valley in every 30; period_end every 30 cycles; a mode switch requested mid-period takes effect only after the boundary.
6. PRESCALE = 3 instance, duty = 5, pol ch0 = 1, en dropped at cnt = 9 and restored 4 cycles later → the period is 45 cycles; ch0 is inverted (low 15 cycles of 45); while en = 0, ch0 = 1 and cnt = 0; the restart is at cnt = 0 with no period_end.
